// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the sized big-endian data memory.
package data_mem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Controller states: clear the array first, then serve requests
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of bytes touched by an access of the given size
  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // Widen right-justified load data to 64 bits; doubles pass through untouched
  function automatic logic [63:0] extend(input logic [63:0] raw,
                                         input logic [1:0]  size,
                                         input logic        unsign);
    logic [63:0] r;
    case (size)
      SZ_B:    r = unsign ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    r = unsign ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    r = unsign ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response delay line with a synchronous active-low flush.
module mem_resp_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         flush_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0]        valid_reg;
  logic [DEPTH-1:0][W-1:0] data_reg;

  // Shift valid and payload one stage per cycle; flush empties every stage
  always_ff @(posedge clk) begin
    if (!flush_n) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      data_reg[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory with sized accesses, error checks,
// a post-reset clear sequence and a fixed read latency.
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  // The array is stored as 8 byte lanes; lane 0 holds the lowest address of
  // each 8-byte row, i.e. the most significant byte of a double.
  localparam int ROWS  = DEPTH_BYTES / 8;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t           state_reg, state_next;
  logic [ROW_W-1:0] clr_cnt_reg, clr_cnt_next;

  logic              init_active;
  logic              accept;
  logic [3:0]        nbytes;
  logic [ADDR_W-1:0] size_mask;
  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic [2:0]        lane_off;
  logic [ROW_W-1:0]  req_row;
  logic [ROW_W-1:0]  wr_row;
  logic [63:0]       raw_load;
  logic [63:0]       load_data;
  logic [DATA_W:0]   pipe_in;
  logic [DATA_W:0]   pipe_out;

  logic       lane_hit   [8];
  logic [2:0] lane_k     [8];
  logic       lane_we    [8];
  logic [7:0] lane_wdata [8];
  logic [7:0] lane_rdata [8];

  assign init_active = rst_n && (state_reg == ST_INIT);
  assign req_ready   = rst_n && (state_reg == ST_READY);
  assign accept      = req_valid && req_ready;

  // Alignment and range check; the single compare against DEPTH-n also
  // rejects huge addresses, so nothing near 2^ADDR_W can wrap into range.
  assign nbytes       = bytes_of(req_size);
  assign size_mask    = ADDR_W'(nbytes) - ADDR_W'(1);
  assign misaligned   = |(req_addr & size_mask);
  assign out_of_range = req_addr > (ADDR_W'(DEPTH_BYTES) - ADDR_W'(nbytes));
  assign access_err   = misaligned || out_of_range;

  // An aligned access never crosses a row, so row + lane offset suffices
  assign lane_off = req_addr[2:0];
  assign req_row  = req_addr[3 +: ROW_W];
  assign wr_row   = init_active ? clr_cnt_reg : req_row;

  // State and clear-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_INIT;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Walk the clear counter over every row once, then serve requests
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        clr_cnt_next = clr_cnt_reg + ROW_W'(1);
        if (clr_cnt_reg == ROW_W'(ROWS - 1)) begin
          state_next = ST_READY;
        end
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // Per-lane steering and storage. Byte k (counting from the LSB of the
  // right-justified data) of an n-byte access lives in lane off+n-1-k.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_mem [ROWS];

    assign lane_hit[gi]   = ({1'b0, lane_off} <= 4'(gi)) &&
                            (4'(gi) < ({1'b0, lane_off} + nbytes));
    assign lane_k[gi]     = lane_off + 3'(nbytes) - 3'd1 - 3'(gi);
    assign lane_we[gi]    = init_active ||
                            (accept && req_write && !access_err && lane_hit[gi]);
    assign lane_wdata[gi] = init_active ? 8'h00 : req_wdata[8*lane_k[gi] +: 8];
    assign lane_rdata[gi] = lane_mem[req_row];

    // Byte write for this lane: zero fill during clear, store data otherwise
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        lane_mem[wr_row] <= lane_wdata[gi];
      end
    end
  end

  // Gather the addressed lanes MSB-first into a right-justified value
  always_comb begin
    raw_load = '0;
    for (int i = 0; i < 8; i++) begin
      if (lane_hit[i]) begin
        raw_load[8*lane_k[i] +: 8] = lane_rdata[i];
      end
    end
  end

  assign load_data = extend(raw_load, req_size, req_unsign);

  // Stores and failed accesses return zero data; idle cycles push all zeros
  always_comb begin
    pipe_in = '0;
    if (accept) begin
      pipe_in[DATA_W] = access_err;
      if (!req_write && !access_err) begin
        pipe_in[DATA_W-1:0] = load_data;
      end
    end
  end

  mem_resp_pipe #(
    .DEPTH (READ_LAT),
    .W     (DATA_W + 1)
  ) u_resp_pipe (
    .clk       (clk),
    .flush_n   (rst_n),
    .in_valid  (accept),
    .in_data   (pipe_in),
    .out_valid (resp_valid),
    .out_data  (pipe_out)
  );

  assign resp_err   = pipe_out[DATA_W];
  assign resp_rdata = pipe_out[DATA_W-1:0];

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench: two instances (read latency 1 and 3) share one stimulus
// stream; every response is checked for data, error flag and arrival cycle.
module tb_data_mem_sized;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_unsign;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;

  logic        ready_a, valid_a, err_a;
  logic [63:0] rdata_a;
  logic        ready_b, valid_b, err_b;
  logic [63:0] rdata_b;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int idle_bad = 0;

  typedef struct {
    int          stamp;
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    string       tag;
    int          stamp;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  resp_t qa[$];
  resp_t qb[$];
  exp_t  eq[$];

  always #5 clk = ~clk;

  data_mem_sized #(.READ_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_write(req_write), .req_size(req_size), .req_unsign(req_unsign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(valid_a), .resp_rdata(rdata_a), .resp_err(err_a)
  );

  data_mem_sized #(.READ_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_write(req_write), .req_size(req_size), .req_unsign(req_unsign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(valid_b), .resp_rdata(rdata_b), .resp_err(err_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Capture responses away from the active edge, stamped with the cycle count
  always @(negedge clk) begin
    if (valid_a) qa.push_back('{cyc, rdata_a, err_a});
    else if (rdata_a != 64'h0 || err_a) idle_bad++;
    if (valid_b) qb.push_back('{cyc, rdata_b, err_b});
    else if (rdata_b != 64'h0 || err_b) idle_bad++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request; call at a negedge, returns at the following negedge
  task automatic send(input string tag, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [63:0] addr, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_err);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_unsign = uns;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    check({tag, "_ready"}, 64'(ready_a & ready_b), 64'h1);
    @(posedge clk);
    #1;
    eq.push_back('{tag, cyc, exp_rd, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Compare every queued expectation against the captured responses
  task automatic drain();
    exp_t  e;
    resp_t r;
    repeat (6) @(negedge clk);
    while (eq.size() != 0) begin
      e = eq.pop_front();
      if (qa.size() == 0) check({e.tag, "_a_present"}, 64'h0, 64'h1);
      else begin
        r = qa.pop_front();
        $display("[TB] %s lat1: cyc=%0d rdata=0x%016h err=%0b", e.tag, r.stamp, r.rdata, r.err);
        check({e.tag, "_a_rdata"}, r.rdata, e.rdata);
        check({e.tag, "_a_err"}, 64'(r.err), 64'(e.err));
        check({e.tag, "_a_cycle"}, 64'(r.stamp), 64'(e.stamp));
      end
      if (qb.size() == 0) check({e.tag, "_b_present"}, 64'h0, 64'h1);
      else begin
        r = qb.pop_front();
        $display("[TB] %s lat3: cyc=%0d rdata=0x%016h err=%0b", e.tag, r.stamp, r.rdata, r.err);
        check({e.tag, "_b_rdata"}, r.rdata, e.rdata);
        check({e.tag, "_b_err"}, 64'(r.err), 64'(e.err));
        check({e.tag, "_b_cycle"}, 64'(r.stamp), 64'(e.stamp + 2));
      end
    end
    check("a_no_extra", 64'(qa.size()), 64'h0);
    check("b_no_extra", 64'(qb.size()), 64'h0);
    qa.delete();
    qb.delete();
  endtask

  // Release reset at a negedge and count cycles until both report ready
  task automatic release_and_wait_init(input string tag);
    int cnt;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cnt = 0;
    while (!ready_a && cnt < 300) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    $display("[TB] %s: ready after %0d cycles", tag, cnt);
    check({tag, "_init_cycles"}, 64'(cnt), 64'd128);
    check({tag, "_b_ready"}, 64'(ready_b), 64'h1);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = SZ_B;
    req_unsign = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(ready_a | ready_b), 64'h0);
    check("rst_valid", 64'(valid_a | valid_b), 64'h0);
    check("rst_rdata", rdata_a | rdata_b, 64'h0);
    check("rst_err", 64'(err_a | err_b), 64'h0);

    // 1. Clear sequence and first load
    release_and_wait_init("init1");
    send("ld_d_000", 1'b0, SZ_D, 1'b0, 64'h000, 64'h0, 64'h0, 1'b0);
    drain();

    // 2/3. Word store, signed/unsigned loads, byte overwrite, lane order
    send("st_w_010", 1'b1, SZ_W, 1'b0, 64'h010, 64'h0000_0000_DEAD_BEEF, 64'h0, 1'b0);
    send("ld_ws_010", 1'b0, SZ_W, 1'b0, 64'h010, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    send("ld_wu_010", 1'b0, SZ_W, 1'b1, 64'h010, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0);
    send("st_b_013", 1'b1, SZ_B, 1'b0, 64'h013, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 1'b0);
    send("ld_bs_013", 1'b0, SZ_B, 1'b0, 64'h013, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send("ld_wu_010b", 1'b0, SZ_W, 1'b1, 64'h010, 64'h0, 64'h0000_0000_DEAD_BE80, 1'b0);
    send("ld_hs_012", 1'b0, SZ_H, 1'b0, 64'h012, 64'h0, 64'hFFFF_FFFF_FFFF_BE80, 1'b0);
    send("ld_bu_010", 1'b0, SZ_B, 1'b1, 64'h010, 64'h0, 64'h0000_0000_0000_00DE, 1'b0);
    drain();

    // 4. Misalignment and range errors leave memory untouched
    send("st_h_011", 1'b1, SZ_H, 1'b0, 64'h011, 64'h1234, 64'h0, 1'b1);
    send("ld_d_004", 1'b0, SZ_D, 1'b0, 64'h004, 64'h0, 64'h0, 1'b1);
    send("ld_wu_010c", 1'b0, SZ_W, 1'b1, 64'h010, 64'h0, 64'h0000_0000_DEAD_BE80, 1'b0);
    send("ld_w_3fe", 1'b0, SZ_W, 1'b0, 64'h3FE, 64'h0, 64'h0, 1'b1);
    send("ld_w_wrap", 1'b0, SZ_W, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b1);
    send("ld_w_400", 1'b0, SZ_W, 1'b0, 64'h400, 64'h0, 64'h0, 1'b1);
    send("st_w_400", 1'b1, SZ_W, 1'b0, 64'h400, 64'hCAFE_F00D, 64'h0, 1'b1);
    send("st_d_3f8", 1'b1, SZ_D, 1'b0, 64'h3F8, 64'h0102_0304_0506_0708, 64'h0, 1'b0);
    send("ld_bu_3ff", 1'b0, SZ_B, 1'b1, 64'h3FF, 64'h0, 64'h08, 1'b0);
    send("ld_bu_3f8", 1'b0, SZ_B, 1'b1, 64'h3F8, 64'h0, 64'h01, 1'b0);
    drain();

    // 5. Back-to-back store/load, partial store keeps neighbours
    send("st_d_020", 1'b1, SZ_D, 1'b0, 64'h020, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
    send("ld_d_020", 1'b0, SZ_D, 1'b1, 64'h020, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
    send("st_h_028", 1'b1, SZ_H, 1'b0, 64'h028, 64'hFFFF_FFFF_FFFF_ABCD, 64'h0, 1'b0);
    send("ld_d_028", 1'b0, SZ_D, 1'b0, 64'h028, 64'h0, 64'hABCD_0000_0000_0000, 1'b0);
    drain();

    // 6. Reset with responses in flight, then verify the array was cleared
    send("fl_ld_020", 1'b0, SZ_D, 1'b0, 64'h020, 64'h0, 64'h0, 1'b0);
    send("fl_ld_010", 1'b0, SZ_W, 1'b0, 64'h010, 64'h0, 64'h0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("flush_a_count", 64'(qa.size()), 64'd2);
    check("flush_b_count", 64'(qb.size()), 64'd0);
    check("flush_ready", 64'(ready_a | ready_b), 64'h0);
    eq.delete();
    qa.delete();
    qb.delete();
    release_and_wait_init("init2");
    check("post_rst_b_quiet", 64'(qb.size()), 64'd0);
    send("ld_d_020_clr", 1'b0, SZ_D, 1'b0, 64'h020, 64'h0, 64'h0, 1'b0);
    send("ld_w_010_clr", 1'b0, SZ_W, 1'b0, 64'h010, 64'h0, 64'h0, 1'b0);
    send("ld_d_3f8_clr", 1'b0, SZ_D, 1'b0, 64'h3F8, 64'h0, 64'h0, 1'b0);
    drain();

    check("idle_rdata_zero", 64'(idle_bad), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the bench always ends even if the design wedges
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
